// File: rtl/pc_pkg.sv
// Shared types and widths for the X9 program-counter sequencer.
// The optional call/return stack is enabled by defining PC_CALL_STACK_EN.
package pc_pkg;

   localparam int PC_W          = 12;
   localparam int LUT_W         = 4;
   localparam int STK_DEPTH_DEF = 4;

   // IDLE: waiting for start, RUN: executing, DONE: halted until restarted.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_sequencer_call_stack.sv
// Call/return LIFO for the PC sequencer.
// The stack is held as a shift register, so the newest entry always sits in
// slot 0. This avoids any variable indexing into the storage.
// Only instantiated when PC_CALL_STACK_EN is defined.
module call_stack
   import pc_pkg::*;
#(
   parameter int W     = PC_W,
   parameter int DEPTH = STK_DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   // A push into a full stack and a pop from an empty one are both dropped here.
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear && !push;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign top   = mem[0];

   // Occupancy counter; clear empties the stack without touching storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (do_push) begin
         count <= count + CW'(1);
      end else if (do_pop) begin
         count <= count - CW'(1);
      end
   end

   // Shift storage down on push and up on pop so slot 0 is always the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[0] <= push_data;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end else if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem[i] <= mem[i+1];
         end
         mem[DEPTH-1] <= '0;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the X9 core.
// Holds the architectural PC, runs the IDLE/RUN/DONE control FSM and drives
// the index side of the combinational branch-target LUT.
// Define PC_CALL_STACK_EN to build the call/return stack; without it call_en
// acts as a plain branch, ret_en is ignored and stk_err is tied low.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int D         = PC_W,
   parameter int L         = LUT_W,
   parameter int STK_DEPTH = STK_DEPTH_DEF
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         start,
   input  logic         halt_req,
   input  logic         stall,
   input  logic         branch_en,
   input  logic         call_en,
   input  logic         ret_en,
   input  logic [L-1:0] lut_idx,
   output logic [L-1:0] lut_addr,
   input  logic [D-1:0] lut_target,
   output logic [D-1:0] prog_ctr,
   output logic         running,
   output logic         done,
   output logic         stk_err
);

   pc_state_t    state;
   pc_state_t    next_state;
   logic [D-1:0] next_pc;
   logic [D-1:0] pc_inc;
   logic         enter_run;
   logic         advance;

   // The LUT sits outside; its index is passed straight through with no register.
   assign lut_addr = lut_idx;

   // Sequential PC plus one; the top value wraps silently to zero.
   assign pc_inc = prog_ctr + D'(1);

   // Every entry into RUN restarts execution from PC 0 with a clean stack.
   assign enter_run = (state != RUN) && (next_state == RUN);

   // PC only moves in RUN when neither halt nor stall holds it.
   assign advance = (state == RUN) && !halt_req && !stall;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; start while already running is ignored.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start)    next_state = RUN;
         RUN:     if (halt_req) next_state = DONE;
         DONE:    if (start)    next_state = RUN;
         default:               next_state = IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      running = (state == RUN);
      done    = (state == DONE);
   end

`ifdef PC_CALL_STACK_EN

   logic         do_push;
   logic         do_pop;
   logic         set_err;
   logic [D-1:0] stk_top;
   logic         stk_full;
   logic         stk_empty;

   call_stack #(
      .W     (D),
      .DEPTH (STK_DEPTH)
   ) u_call_stack (
      .clk       (Clk),
      .rst       (Reset),
      .clear     (enter_run),
      .push      (do_push),
      .pop       (do_pop),
      .push_data (pc_inc),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // Next-PC selection with return above call above branch above increment.
   always_comb begin
      next_pc = prog_ctr;
      do_push = 1'b0;
      do_pop  = 1'b0;
      set_err = 1'b0;
      if (advance) begin
         if (ret_en) begin
            if (stk_empty) begin
               set_err = 1'b1;
               next_pc = pc_inc;
            end else begin
               do_pop  = 1'b1;
               next_pc = stk_top;
            end
         end else if (call_en) begin
            if (stk_full) begin
               set_err = 1'b1;
            end else begin
               do_push = 1'b1;
            end
            next_pc = lut_target;
         end else if (branch_en) begin
            next_pc = lut_target;
         end else begin
            next_pc = pc_inc;
         end
      end
   end

   // Sticky stack error, cleared only by reset or a fresh entry into RUN.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stk_err <= 1'b0;
      end else if (enter_run) begin
         stk_err <= 1'b0;
      end else if (set_err) begin
         stk_err <= 1'b1;
      end
   end

`else

   logic unused_ret;
   localparam int unused_stk_depth = STK_DEPTH;

   assign unused_ret = ret_en;
   assign stk_err    = 1'b0;

   // Next-PC selection; a call is just a branch and a return falls through to increment.
   always_comb begin
      next_pc = prog_ctr;
      if (advance) begin
         if (call_en || branch_en) begin
            next_pc = lut_target;
         end else begin
            next_pc = pc_inc;
         end
      end
   end

`endif

   // PC register; restarts at zero whenever execution (re)enters RUN.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         prog_ctr <= '0;
      end else if (enter_run) begin
         prog_ctr <= '0;
      end else begin
         prog_ctr <= next_pc;
      end
   end

endmodule
